param_rs: RTL

PARAM_RS -- requirements
Module: param_rs

---
 rtl/param_rs.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/param_rs.sv
// param_rs: parameterised reservation station with multi-lane dispatch, CDB wakeup, issue and branch resolution.
// Defining RS_CDB_BYPASS_EN marks dispatched sources ready when they match a same-cycle CDB broadcast.
module param_rs #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 3,
  parameter int CDB_W     = 3,
  parameter int TAG_W     = 6,
  parameter int BMASK_W   = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [$clog2(DISP_W+1)-1:0]    disp_num,
  input  logic [DISP_W*TAG_W-1:0]        disp_src1_tag,
  input  logic [DISP_W*TAG_W-1:0]        disp_src2_tag,
  input  logic [DISP_W-1:0]              disp_src1_rdy,
  input  logic [DISP_W-1:0]              disp_src2_rdy,
  input  logic [DISP_W*BMASK_W-1:0]      disp_bmask,
  input  logic [DISP_W*PAYLOAD_W-1:0]    disp_payload,
  output logic [$clog2(DEPTH+1)-1:0]     free_cnt,
  input  logic [CDB_W-1:0]               cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]         cdb_tag,
  input  logic [DEPTH-1:0]               issue_clear,
  output logic [DEPTH-1:0]               entry_valid,
  output logic [DEPTH-1:0]               entry_ready,
  output logic [DEPTH*BMASK_W-1:0]       entry_bmask,
  output logic [DEPTH*PAYLOAD_W-1:0]     entry_payload,
  input  logic                           br_valid,
  input  logic [BMASK_W-1:0]             br_mask,
  input  logic                           br_mispred
);
  localparam int FC_W = $clog2(DEPTH+1);
  localparam int LN_W = $clog2(DISP_W+1);

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [CDB_W-1:0] vld,
                                   input logic [CDB_W*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      hit = hit | (vld[c] && (tags[c*TAG_W +: TAG_W] == tag));
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_rdy1;
  logic [DEPTH-1:0]     r_rdy2;
  logic [TAG_W-1:0]     r_tag1    [DEPTH];
  logic [TAG_W-1:0]     r_tag2    [DEPTH];
  logic [BMASK_W-1:0]   r_bmask   [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];

  logic [FC_W-1:0]      w_free_cnt;
  logic [DEPTH-1:0]     w_alloc;
  logic [LN_W-1:0]      w_lane    [DEPTH];
  logic [TAG_W-1:0]     w_d_tag1  [DEPTH];
  logic [TAG_W-1:0]     w_d_tag2  [DEPTH];
  logic [BMASK_W-1:0]   w_d_bmask [DEPTH];
  logic [PAYLOAD_W-1:0] w_d_pay   [DEPTH];
  logic [DEPTH-1:0]     w_d_rdy1;
  logic [DEPTH-1:0]     w_d_rdy2;
  logic [DEPTH-1:0]     w_d_kill;
  logic [DEPTH-1:0]     w_wake1;
  logic [DEPTH-1:0]     w_wake2;
  logic                 w_br_squash;
  logic [BMASK_W-1:0]   w_keep_mask;

  assign w_br_squash = br_valid & br_mispred;
  assign w_keep_mask = (br_valid & ~br_mispred) ? ~br_mask : {BMASK_W{1'b1}};

  // Free-entry count from current state only; slots freed this cycle are not counted.
  always_comb begin
    w_free_cnt = {FC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_free_cnt = w_free_cnt + FC_W'(~r_valid[i]);
    end
  end

  // Lane k goes to the k-th lowest free entry; lanes with no free entry are dropped.
  always_comb begin
    int n;
    int lim;
    lim = (int'(disp_num) > DISP_W) ? DISP_W : int'(disp_num);
    n   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_valid[i] && (n < lim)) begin
        w_alloc[i] = 1'b1;
        w_lane[i]  = LN_W'(n);
        n          = n + 1;
      end else begin
        w_alloc[i] = 1'b0;
        w_lane[i]  = {LN_W{1'b0}};
      end
    end
  end

  // Per-entry view of the selected dispatch lane plus CDB wakeup of stored tags.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_d_tag1[i]  = disp_src1_tag[w_lane[i]*TAG_W +: TAG_W];
      w_d_tag2[i]  = disp_src2_tag[w_lane[i]*TAG_W +: TAG_W];
      w_d_bmask[i] = disp_bmask[w_lane[i]*BMASK_W +: BMASK_W];
      w_d_pay[i]   = disp_payload[w_lane[i]*PAYLOAD_W +: PAYLOAD_W];
      w_d_kill[i]  = w_br_squash & (|(w_d_bmask[i] & br_mask));
`ifdef RS_CDB_BYPASS_EN
      w_d_rdy1[i]  = disp_src1_rdy[w_lane[i]] | cdb_hit(w_d_tag1[i], cdb_valid, cdb_tag);
      w_d_rdy2[i]  = disp_src2_rdy[w_lane[i]] | cdb_hit(w_d_tag2[i], cdb_valid, cdb_tag);
`else
      w_d_rdy1[i]  = disp_src1_rdy[w_lane[i]];
      w_d_rdy2[i]  = disp_src2_rdy[w_lane[i]];
`endif
      w_wake1[i]   = cdb_hit(r_tag1[i], cdb_valid, cdb_tag);
      w_wake2[i]   = cdb_hit(r_tag2[i], cdb_valid, cdb_tag);
    end
  end

  // Entry state update: reset > squash > issue > wakeup/allocate.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= {DEPTH{1'b0}};
      r_rdy1  <= {DEPTH{1'b0}};
      r_rdy2  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_bmask[i] <= {BMASK_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i]) begin
          if ((w_br_squash && (|(r_bmask[i] & br_mask))) || issue_clear[i]) begin
            r_valid[i] <= 1'b0;
            r_rdy1[i]  <= 1'b0;
            r_rdy2[i]  <= 1'b0;
          end else begin
            r_rdy1[i]  <= r_rdy1[i] | w_wake1[i];
            r_rdy2[i]  <= r_rdy2[i] | w_wake2[i];
            r_bmask[i] <= r_bmask[i] & w_keep_mask;
          end
        end else if (w_alloc[i]) begin
          r_valid[i]   <= ~w_d_kill[i];
          r_rdy1[i]    <= w_d_rdy1[i];
          r_rdy2[i]    <= w_d_rdy2[i];
          r_tag1[i]    <= w_d_tag1[i];
          r_tag2[i]    <= w_d_tag2[i];
          r_bmask[i]   <= w_d_bmask[i] & w_keep_mask;
          r_payload[i] <= w_d_pay[i];
        end else begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign free_cnt    = w_free_cnt;
  assign entry_valid = r_valid;
  assign entry_ready = r_valid & r_rdy1 & r_rdy2;

  for (genvar g = 0; g < DEPTH; g++) begin : g_out
    assign entry_bmask[g*BMASK_W +: BMASK_W]       = r_bmask[g];
    assign entry_payload[g*PAYLOAD_W +: PAYLOAD_W] = r_payload[g];
  end

`ifndef SYNTHESIS
  param_rs_chk #(.LN_W(LN_W), .FC_W(FC_W)) u_chk (
    .clock    (clock),
    .reset    (reset),
    .disp_num (disp_num),
    .free_cnt (w_free_cnt)
  );
`endif
endmodule

// param_rs_chk: simulation-only protocol check for dispatch overflow.
module param_rs_chk #(
  parameter int LN_W = 2,
  parameter int FC_W = 5
) (
  input logic            clock,
  input logic            reset,
  input logic [LN_W-1:0] disp_num,
  input logic [FC_W-1:0] free_cnt
);
  // Dispatching more lanes than free entries drops the excess lanes.
  always @(posedge clock) begin
    if (!reset) begin
      assert (int'(disp_num) <= int'(free_cnt))
        else $warning("param_rs: disp_num %0d exceeds free_cnt %0d", disp_num, free_cnt);
    end
  end
endmodule
